cascade_pi_pwm: RTL and testbench

Two-loop (outer/inner) PI controller with an integrated center-aligned PWM generator. It is the parametrised successor to the fixed cascaded control path in the motor-drive top level. The block takes ADC setpoint/measurement samples on a strobe, computes both loops with a shared multiplier in a fixed 7-cycle sequence, and applies saturation with integrator clamping. The resulting duty is updated glitch-free at the carrier valley.

---
 rtl/cascade_pi_pwm.sv | 225 ++++++++++++++++++++++
 tb/tb_cascade_pi_pwm.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_pi_pwm.sv
// cascade_pi_pwm
// Cascaded outer/inner PI controller sharing one signed multiplier, followed by
// a center-aligned (triangle carrier) PWM generator.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            run control; low aborts the computation and clears the
//                     controller state
//   sample_valid      one-cycle strobe qualifying setpoint/meas_outer/meas_inner
//   setpoint          outer loop reference (unsigned W bits)
//   meas_outer        outer loop feedback (unsigned W bits)
//   meas_inner        inner loop feedback (unsigned W bits)
//   busy              computation in progress (including the duty_valid cycle)
//   overrun           one-cycle pulse after a strobe that arrived while busy
//   duty_valid        one-cycle pulse when a new duty is latched
//   duty              latest computed duty (shadow register)
//   sat_outer         outer output clamp engaged at its last update
//   sat_inner         inner output clamp engaged at its last update
//   pwm_out           registered PWM output
module cascade_pi_pwm #(
  parameter int                 W        = 12,
  parameter int                 DW       = 16,
  parameter int                 FRAC     = 8,
  parameter logic signed [15:0] KP_O     = 16'sd256,
  parameter logic signed [15:0] KI_O     = 16'sd16,
  parameter logic signed [15:0] KP_I     = 16'sd256,
  parameter logic signed [15:0] KI_I     = 16'sd16,
  parameter int                 O_MIN    = -2048,
  parameter int                 O_MAX    = 2047,
  parameter int                 PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [W-1:0]        setpoint,
  input  logic [W-1:0]        meas_outer,
  input  logic [W-1:0]        meas_inner,
  output logic                busy,
  output logic                overrun,
  output logic                duty_valid,
  output logic [PWM_BITS-1:0] duty,
  output logic                sat_outer,
  output logic                sat_inner,
  output logic                pwm_out
);

  localparam int PW = 16 + DW;   // full-precision product width
  localparam int SW = PW + 1;    // one bit wider so the sum cannot wrap before clamping
  localparam logic [PWM_BITS-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    IDLE, O_ERR, O_INT, O_OUT, I_ERR, I_INT, I_OUT
  } state_t;

  state_t state, state_next;

  logic [W-1:0]          setpoint_r, meas_outer_r, meas_inner_r;
  logic signed [DW-1:0]  e_o, e_i, i_o, i_i, u_o;
  logic signed [W:0]     e_o_raw;

  logic signed [15:0]    mul_k;
  logic signed [DW-1:0]  mul_x, acc_in;
  logic signed [PW-1:0]  prod, prod_sh;
  logic signed [SW-1:0]  sum, lo, hi;
  logic signed [DW-1:0]  clamp_val;
  logic                  clamp_sat;
  logic                  accept;

  logic [PWM_BITS-1:0]   cnt;
  logic                  cnt_up;
  logic [PWM_BITS-1:0]   active_duty;

  // The duty_valid cycle also counts as busy so a new strobe is only taken one
  // cycle after the result appears.
  assign busy   = (state != IDLE) || duty_valid;
  assign accept = (state == IDLE) && !duty_valid && sample_valid && enable;

  assign e_o_raw = $signed({1'b0, setpoint_r}) - $signed({1'b0, meas_outer_r});

  // Shared multiplier and accumulate/clamp path: one product per state.
  always_comb begin
    mul_k  = '0;
    mul_x  = '0;
    acc_in = '0;
    lo     = SW'(O_MIN);
    hi     = SW'(O_MAX);
    unique case (state)
      O_INT: begin mul_k = KI_O; mul_x = e_o; acc_in = i_o; end
      O_OUT: begin mul_k = KP_O; mul_x = e_o; acc_in = i_o; end
      I_INT: begin
        mul_k = KI_I; mul_x = e_i; acc_in = i_i;
        lo = '0; hi = SW'($signed({1'b0, CMAX}));
      end
      I_OUT: begin
        mul_k = KP_I; mul_x = e_i; acc_in = i_i;
        lo = '0; hi = SW'($signed({1'b0, CMAX}));
      end
      default: ;
    endcase
  end

  assign prod    = PW'(mul_k) * PW'(mul_x);
  assign prod_sh = prod >>> FRAC;
  assign sum     = SW'(prod_sh) + SW'(acc_in);

  always_comb begin
    clamp_val = sum[DW-1:0];
    clamp_sat = 1'b0;
    if (sum < lo) begin
      clamp_val = lo[DW-1:0];
      clamp_sat = 1'b1;
    end else if (sum > hi) begin
      clamp_val = hi[DW-1:0];
      clamp_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_next = O_ERR;
        O_ERR:   state_next = O_INT;
        O_INT:   state_next = O_OUT;
        O_OUT:   state_next = I_ERR;
        I_ERR:   state_next = I_INT;
        I_INT:   state_next = I_OUT;
        I_OUT:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setpoint_r   <= '0;
      meas_outer_r <= '0;
      meas_inner_r <= '0;
      e_o          <= '0;
      e_i          <= '0;
      i_o          <= '0;
      i_i          <= '0;
      u_o          <= '0;
      duty         <= '0;
      duty_valid   <= 1'b0;
      overrun      <= 1'b0;
      sat_outer    <= 1'b0;
      sat_inner    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      overrun    <= sample_valid && enable && busy;
      if (!enable) begin
        i_o       <= '0;
        i_i       <= '0;
        u_o       <= '0;
        duty      <= '0;
        sat_outer <= 1'b0;
        sat_inner <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            setpoint_r   <= setpoint;
            meas_outer_r <= meas_outer;
            meas_inner_r <= meas_inner;
          end
          O_ERR: e_o <= DW'(e_o_raw);
          O_INT: i_o <= clamp_val;
          O_OUT: begin
            u_o       <= clamp_val;
            sat_outer <= clamp_sat;
          end
          I_ERR: e_i <= u_o - $signed(DW'({1'b0, meas_inner_r}));
          I_INT: i_i <= clamp_val;
          I_OUT: begin
            duty       <= clamp_val[PWM_BITS-1:0];
            sat_inner  <= clamp_sat;
            duty_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Triangle carrier 0..CMAX..1; the shadow duty is taken only at the valley so
  // the output never glitches mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      cnt_up      <= 1'b1;
      active_duty <= '0;
      pwm_out     <= 1'b0;
    end else begin
      if (cnt_up) begin
        if (cnt == CMAX) begin
          cnt    <= cnt - 1'b1;
          cnt_up <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        if (cnt == PWM_BITS'(1)) begin
          cnt    <= '0;
          cnt_up <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end

      if (!enable)                   active_duty <= '0;
      else if (cnt == '0 && cnt_up)  active_duty <= duty;

      pwm_out <= (active_duty > cnt);
    end
  end

endmodule

// File: tb/tb_cascade_pi_pwm.sv
module tb_cascade_pi_pwm;

  localparam int W = 12;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  setpoint = '0, meas_outer = '0, meas_inner = '0;

  // d: default gains, p: proportional only, c: integrator-clamp probe
  logic          d_busy, d_overrun, d_duty_valid, d_sat_outer, d_sat_inner, d_pwm_out;
  logic [PB-1:0] d_duty;
  logic          p_busy, p_overrun, p_duty_valid, p_sat_outer, p_sat_inner, p_pwm_out;
  logic [PB-1:0] p_duty;
  logic          c_busy, c_overrun, c_duty_valid, c_sat_outer, c_sat_inner, c_pwm_out;
  logic [PB-1:0] c_duty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int duty;
    bit so;
    bit si;
  } exp_t;
  exp_t exp_q[$];

  int m_io = 0, m_ii = 0;

  always #5 clk = ~clk;

  cascade_pi_pwm dut_d (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .setpoint(setpoint), .meas_outer(meas_outer), .meas_inner(meas_inner),
    .busy(d_busy), .overrun(d_overrun), .duty_valid(d_duty_valid), .duty(d_duty),
    .sat_outer(d_sat_outer), .sat_inner(d_sat_inner), .pwm_out(d_pwm_out)
  );

  cascade_pi_pwm #(.KI_O(16'sd0), .KI_I(16'sd0)) dut_p (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .setpoint(setpoint), .meas_outer(meas_outer), .meas_inner(meas_inner),
    .busy(p_busy), .overrun(p_overrun), .duty_valid(p_duty_valid), .duty(p_duty),
    .sat_outer(p_sat_outer), .sat_inner(p_sat_inner), .pwm_out(p_pwm_out)
  );

  cascade_pi_pwm #(.KP_O(16'sd0), .KI_O(16'sd256), .KP_I(16'sd16), .KI_I(16'sd0)) dut_c (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .setpoint(setpoint), .meas_outer(meas_outer), .meas_inner(meas_inner),
    .busy(c_busy), .overrun(c_overrun), .duty_valid(c_duty_valid), .duty(c_duty),
    .sat_outer(c_sat_outer), .sat_inner(c_sat_inner), .pwm_out(c_pwm_out)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference cascade in plain integer arithmetic (floor shift by 8).
  task automatic model_step(input int kpo, input int kio, input int kpi, input int kii,
                            input int sp, input int mo, input int mi,
                            inout int io, inout int ii, output exp_t e);
    longint eo, ei, s, uo, ui;
    eo = longint'(sp) - longint'(mo);
    s  = longint'(io) + ((longint'(kio) * eo) >>> 8);
    io = (s < -2048) ? -2048 : (s > 2047) ? 2047 : int'(s);
    s  = ((longint'(kpo) * eo) >>> 8) + longint'(io);
    e.so = (s < -2048) || (s > 2047);
    uo = (s < -2048) ? -2048 : (s > 2047) ? 2047 : s;
    ei = uo - longint'(mi);
    s  = longint'(ii) + ((longint'(kii) * ei) >>> 8);
    ii = (s < 0) ? 0 : (s > 255) ? 255 : int'(s);
    s  = ((longint'(kpi) * ei) >>> 8) + longint'(ii);
    e.si = (s < 0) || (s > 255);
    ui = (s < 0) ? 0 : (s > 255) ? 255 : s;
    e.duty = int'(ui);
  endtask

  task automatic push_default(input int sp, input int mo, input int mi);
    exp_t e;
    model_step(256, 16, 256, 16, sp, mo, mi, m_io, m_ii, e);
    exp_q.push_back(e);
  endtask

  task automatic clear_ctrl;
    enable = 1'b0;
    sample_valid = 1'b0;
    tick; tick;
    enable = 1'b1;
    m_io = 0;
    m_ii = 0;
    exp_q.delete();
  endtask

  // Drive a one-cycle strobe; returns at cycle 1 relative to the strobe.
  task automatic strobe(input int sp, input int mo, input int mi);
    setpoint = W'(sp); meas_outer = W'(mo); meas_inner = W'(mi);
    sample_valid = 1'b1;
    tick;
    sample_valid = 1'b0;
  endtask

  task automatic get_dv(input int which, output bit dv);
    case (which)
      0: dv = (d_duty_valid === 1'b1);
      1: dv = (p_duty_valid === 1'b1);
      default: dv = (c_duty_valid === 1'b1);
    endcase
  endtask

  // Called at cycle 1; stops on the duty_valid cycle (cyc = cycle index).
  task automatic wait_dv(input int which, input int budget, output int cyc, output bit seen);
    bit dv;
    seen = 1'b0;
    cyc = 1;
    while (!seen && cyc <= budget) begin
      get_dv(which, dv);
      if (dv) seen = 1'b1;
      else begin tick; cyc++; end
    end
  endtask

  task automatic count_high(input int which, input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      case (which)
        0: highs += (d_pwm_out === 1'b1) ? 1 : 0;
        1: highs += (p_pwm_out === 1'b1) ? 1 : 0;
        default: highs += (c_pwm_out === 1'b1) ? 1 : 0;
      endcase
      tick;
    end
  endtask

  task automatic test_reset;
    int highs;
    rst = 1'b1;
    enable = 1'b0;
    repeat (5) tick;
    checks++;
    if ({d_busy, d_overrun, d_duty_valid, d_sat_outer, d_sat_inner, d_pwm_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {d_busy, d_overrun, d_duty_valid, d_sat_outer, d_sat_inner, d_pwm_out});
    end
    checks++;
    if (d_duty !== 8'd0) begin
      errors++;
      $display("FAIL reset_duty: got %0d expected 0", d_duty);
    end
    rst = 1'b0;
    enable = 1'b1;
    count_high(0, 1020, highs);
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL reset_pwm_idle: got %0d high cycles expected 0", highs);
    end
  endtask

  task automatic test_proportional;
    int lat, busy_bad, highs;
    exp_t e;
    clear_ctrl;
    exp_q.push_back('{duty: 60, so: 1'b0, si: 1'b0});
    strobe(200, 100, 40);
    lat = 0;
    busy_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 8 && p_busy !== (k <= 7)) busy_bad++;
      if (p_duty_valid === 1'b1 && lat == 0) begin
        lat = k;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL prop_scoreboard: duty_valid with empty queue, duty %0d", p_duty);
        end else begin
          e = exp_q.pop_front();
          if (p_duty !== PB'(e.duty)) begin
            errors++;
            $display("FAIL prop_duty: got %0d expected %0d", p_duty, e.duty);
          end
        end
      end
      tick;
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL prop_latency: got %0d expected 7", lat);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL prop_busy_window: got %0d bad cycles expected 0", busy_bad);
    end
    repeat (520) tick;
    for (int p = 0; p < 2; p++) begin
      count_high(1, 510, highs);
      checks++;
      if (highs !== 119) begin
        errors++;
        $display("FAIL prop_pwm_period%0d: got %0d high cycles expected 119", p, highs);
      end
    end
  endtask

  task automatic test_saturation;
    int cyc;
    bit seen;
    exp_t e;
    clear_ctrl;
    push_default(4095, 0, 0);
    strobe(4095, 0, 0);
    wait_dv(0, 20, cyc, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sat_timeout: got no duty_valid expected one within 20 cycles");
    end else begin
      e = exp_q.pop_front();
      if ({d_duty, d_sat_outer, d_sat_inner} !== {PB'(e.duty), e.so, e.si}) begin
        errors++;
        $display("FAIL sat_result: got duty %0d so %b si %b expected duty %0d so %b si %b",
                 d_duty, d_sat_outer, d_sat_inner, e.duty, e.so, e.si);
      end
    end
    checks++;
    if (d_duty !== 8'd255) begin
      errors++;
      $display("FAIL sat_duty_full: got %0d expected 255", d_duty);
    end
  endtask

  task automatic test_integrator_clamp;
    int cyc;
    bit seen;
    int exp_c[5] = '{62, 125, 127, 127, 127};
    clear_ctrl;
    for (int s = 0; s < 5; s++) begin
      strobe(1000, 0, 0);
      wait_dv(2, 9, cyc, seen);
      checks++;
      if (!seen || c_duty !== PB'(exp_c[s])) begin
        errors++;
        $display("FAIL int_clamp_step%0d: got duty %0d (valid %b) expected %0d",
                 s, c_duty, seen, exp_c[s]);
      end
      repeat (10 - cyc) tick;
    end
  endtask

  task automatic test_overrun;
    int ov_n, ov_k, dv_n, dv_k;
    exp_t e;
    clear_ctrl;
    push_default(200, 100, 40);
    strobe(200, 100, 40);
    ov_n = 0; ov_k = 0; dv_n = 0; dv_k = 0;
    for (int k = 1; k <= 30; k++) begin
      if (d_overrun === 1'b1) begin ov_n++; ov_k = k; end
      if (d_duty_valid === 1'b1) begin
        dv_n++;
        dv_k = k;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '{duty: -1, so: 1'b0, si: 1'b0};
        if (d_duty !== PB'(e.duty) || e.duty < 0) begin
          errors++;
          $display("FAIL overrun_duty: got %0d expected %0d", d_duty, e.duty);
        end
      end
      sample_valid = (k == 3);
      if (k == 3) begin setpoint = 12'd4095; meas_outer = '0; meas_inner = '0; end
      tick;
    end
    sample_valid = 1'b0;
    checks++;
    if (ov_n !== 1 || ov_k !== 4) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses last at cycle %0d expected 1 at cycle 4", ov_n, ov_k);
    end
    checks++;
    if (dv_n !== 1 || dv_k !== 7) begin
      errors++;
      $display("FAIL overrun_single_dv: got %0d pulses last at cycle %0d expected 1 at cycle 7", dv_n, dv_k);
    end
  endtask

  task automatic test_back_to_back;
    int ov_n, ov_k, dv_n;
    int dv_k[2];
    exp_t e;
    clear_ctrl;
    push_default(200, 100, 40);
    strobe(200, 100, 40);
    ov_n = 0; ov_k = 0; dv_n = 0; dv_k = '{0, 0};
    for (int k = 1; k <= 30; k++) begin
      if (d_overrun === 1'b1) begin ov_n++; ov_k = k; end
      if (d_duty_valid === 1'b1) begin
        if (dv_n < 2) dv_k[dv_n] = k;
        dv_n++;
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '{duty: -1, so: 1'b0, si: 1'b0};
        if (d_duty !== PB'(e.duty) || e.duty < 0) begin
          errors++;
          $display("FAIL b2b_duty: got %0d expected %0d at cycle %0d", d_duty, e.duty, k);
        end
      end
      sample_valid = (k == 7) || (k == 8);
      if (k == 8) push_default(200, 100, 40);
      tick;
    end
    sample_valid = 1'b0;
    checks++;
    if (dv_n !== 2 || dv_k[0] !== 7 || dv_k[1] !== 15) begin
      errors++;
      $display("FAIL b2b_dv_timing: got %0d pulses at %0d,%0d expected 2 at 7,15", dv_n, dv_k[0], dv_k[1]);
    end
    checks++;
    if (ov_n !== 1 || ov_k !== 8) begin
      errors++;
      $display("FAIL b2b_overrun: got %0d pulses last at %0d expected 1 at 8", ov_n, ov_k);
    end
  endtask

  task automatic test_abort;
    int cyc, dv_n;
    bit seen;
    exp_t e;
    clear_ctrl;
    push_default(200, 100, 40);
    strobe(200, 100, 40);
    wait_dv(0, 20, cyc, seen);
    if (seen) void'(exp_q.pop_front());
    repeat (3) tick;
    strobe(200, 100, 40);
    dv_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (d_duty_valid === 1'b1) dv_n++;
      enable = (k != 4);
      tick;
    end
    checks++;
    if (dv_n !== 0) begin
      errors++;
      $display("FAIL abort_no_dv: got %0d pulses expected 0", dv_n);
    end
    checks++;
    if ({d_duty, d_sat_outer, d_sat_inner} !== 10'd0) begin
      errors++;
      $display("FAIL abort_cleared: got duty %0d so %b si %b expected 0 0 0", d_duty, d_sat_outer, d_sat_inner);
    end
    m_io = 0;
    m_ii = 0;
    exp_q.delete();
    push_default(200, 100, 40);
    strobe(200, 100, 40);
    wait_dv(0, 20, cyc, seen);
    checks++;
    e = exp_q.pop_front();
    if (!seen || d_duty !== PB'(e.duty)) begin
      errors++;
      $display("FAIL abort_integrators_zero: got duty %0d (valid %b) expected %0d", d_duty, seen, e.duty);
    end
  endtask

  task automatic test_async_reset;
    int n;
    n = 0;
    while (d_pwm_out !== 1'b1 && n < 600) begin tick; n++; end
    checks++;
    if (d_pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL arst_pwm_high_before: got %b expected 1 within 600 cycles", d_pwm_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (d_pwm_out !== 1'b0 || dut_d.cnt !== 8'd0 || d_duty !== 8'd0) begin
      errors++;
      $display("FAIL arst_immediate: got pwm %b cnt %0d duty %0d expected 0 0 0", d_pwm_out, dut_d.cnt, d_duty);
    end
    repeat (3) tick;
    rst = 1'b0;
    tick;
    checks++;
    if (dut_d.cnt !== 8'd1 || dut_d.cnt_up !== 1'b1) begin
      errors++;
      $display("FAIL arst_cnt_restart: got cnt %0d up %b expected 1 1", dut_d.cnt, dut_d.cnt_up);
    end
  endtask

  initial begin
    test_reset;
    test_proportional;
    test_saturation;
    test_integrator_clamp;
    test_overrun;
    test_back_to_back;
    test_abort;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
